// File: rtl/neuron_sample_feeder_pkg.sv
// Shared types and defaults for the neuron training-data feeder.
package neuron_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      EPOCH_CHECK,
      DONE
   } feeder_state_t;

   localparam int unsigned DATA_W_DEF     = 8;
   localparam int unsigned MAX_EPOCHS_DEF = 16;

   typedef struct packed {
      logic signed [DATA_W_DEF-1:0] x1;
      logic signed [DATA_W_DEF-1:0] x2;
      logic signed [DATA_W_DEF-1:0] t;
   } sample_t;

endpackage

// File: rtl/neuron_sample_feeder_if.sv
// Sample handshake between the feeder (master) and the neuron controller (slave).
interface neuron_sample_feeder_if
   import neuron_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned IDX_W  = 2
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] x1;
   logic [DATA_W-1:0] x2;
   logic [DATA_W-1:0] t;
   logic [IDX_W-1:0]  sample_idx;

   modport master (output valid, x1, x2, t, sample_idx, input ready);
   modport slave  (input valid, x1, x2, t, sample_idx, output ready);
endinterface

// File: rtl/neuron_sample_table.sv
// Sample register file: synchronous write, asynchronous read, contents survive reset.
module neuron_sample_table #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned N_SAMPLES = 4,
   parameter int unsigned IDX_W     = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [3*DATA_W-1:0]   wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [3*DATA_W-1:0]   rdata
);
   logic [3*DATA_W-1:0] mem [N_SAMPLES];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/neuron_sample_feeder.sv
// Presents the sample table to the neuron controller epoch by epoch until convergence
// or MAX_EPOCHS. Define FEEDER_ALT_ORDER_EN to walk odd epochs in descending order.
module neuron_sample_feeder
   import neuron_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned N_SAMPLES  = 4,
   parameter int unsigned MAX_EPOCHS = MAX_EPOCHS_DEF,
   parameter int unsigned IDX_W      = $clog2(N_SAMPLES),
   parameter int unsigned EP_W       = $clog2(MAX_EPOCHS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 load_en,
   input  logic [IDX_W-1:0]     load_addr,
   input  logic [DATA_W-1:0]    load_x1,
   input  logic [DATA_W-1:0]    load_x2,
   input  logic [DATA_W-1:0]    load_t,
   input  logic                 weight_changed,
   neuron_sample_feeder_if.master smp,
   output logic                 epoch_end,
   output logic [EP_W-1:0]      epoch_cnt,
   output logic                 busy,
   output logic                 done,
   output logic                 converged
);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);
   localparam logic [EP_W-1:0]  EP_MAX   = EP_W'(MAX_EPOCHS);

   feeder_state_t       state, state_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [EP_W-1:0]     epoch_n, ep_inc;
   logic                changed, changed_n, converged_n;
   logic                last, eff, table_we;
   logic [3*DATA_W-1:0] rd;

`ifdef FEEDER_ALT_ORDER_EN
   logic desc, desc_n;
   assign last = desc ? (idx == '0) : (idx == IDX_LAST);
`else
   assign last = (idx == IDX_LAST);
`endif

   assign table_we = load_en && (state == IDLE || state == DONE);

   neuron_sample_table #(
      .DATA_W    (DATA_W),
      .N_SAMPLES (N_SAMPLES),
      .IDX_W     (IDX_W)
   ) u_table (
      .clk   (clk),
      .we    (table_we),
      .waddr (load_addr),
      .wdata ({load_x1, load_x2, load_t}),
      .raddr (idx),
      .rdata (rd)
   );

   assign smp.valid      = (state == PRESENT);
   assign smp.sample_idx = idx;
   assign {smp.x1, smp.x2, smp.t} = smp.valid ? rd : '0;
   assign busy      = (state == PRESENT) || (state == EPOCH_CHECK);
   assign done      = (state == DONE);
   assign epoch_end = (state == EPOCH_CHECK);

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      epoch_n     = epoch_cnt;
      changed_n   = changed;
      converged_n = converged;
`ifdef FEEDER_ALT_ORDER_EN
      desc_n      = desc;
`endif
      ep_inc      = epoch_cnt + 1'b1;
      // an update landing in the EPOCH_CHECK cycle still belongs to the epoch just finished
      eff         = changed | weight_changed;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n     = PRESENT;
               idx_n       = '0;
               epoch_n     = '0;
               changed_n   = 1'b0;
               converged_n = 1'b0;
`ifdef FEEDER_ALT_ORDER_EN
               desc_n      = 1'b0;
`endif
            end
         end
         PRESENT: begin
            changed_n = eff;
            if (smp.ready) begin
               if (last) begin
                  state_n = EPOCH_CHECK;
               end else begin
`ifdef FEEDER_ALT_ORDER_EN
                  idx_n = desc ? idx - 1'b1 : idx + 1'b1;
`else
                  idx_n = idx + 1'b1;
`endif
               end
            end
         end
         EPOCH_CHECK: begin
            epoch_n = ep_inc;
            if (!eff) begin
               converged_n = 1'b1;
               state_n     = DONE;
            end else if (ep_inc == EP_MAX) begin
               converged_n = 1'b0;
               state_n     = DONE;
            end else begin
               changed_n = 1'b0;
               state_n   = PRESENT;
`ifdef FEEDER_ALT_ORDER_EN
               desc_n    = ep_inc[0];
               idx_n     = ep_inc[0] ? IDX_LAST : '0;
`else
               idx_n     = '0;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         epoch_cnt <= '0;
         changed   <= 1'b0;
         converged <= 1'b0;
`ifdef FEEDER_ALT_ORDER_EN
         desc      <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         epoch_cnt <= epoch_n;
         changed   <= changed_n;
         converged <= converged_n;
`ifdef FEEDER_ALT_ORDER_EN
         desc      <= desc_n;
`endif
      end
   end
endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Directed bench for neuron_sample_feeder with a 4-entry table and MAX_EPOCHS = 16.
module tb_neuron_sample_feeder;
   import neuron_pkg::*;

`ifdef FEEDER_ALT_ORDER_EN
   localparam bit ALT = 1'b1;
`else
   localparam bit ALT = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       start;
   logic       load_en;
   logic [1:0] load_addr;
   logic [7:0] load_x1, load_x2, load_t;
   logic       weight_changed;
   logic       epoch_end, busy, done, converged;
   logic [4:0] epoch_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] tx1 [4] = '{8'd1, 8'd3, 8'hFE, 8'd0};
   logic [7:0] tx2 [4] = '{8'd2, 8'hFF, 8'd4, 8'd0};
   logic [7:0] tt  [4] = '{8'd1, 8'hFF, 8'd1, 8'hFF};

   neuron_sample_feeder_if #(.DATA_W(8), .IDX_W(2)) smp_if ();

   neuron_sample_feeder #(
      .DATA_W     (8),
      .N_SAMPLES  (4),
      .MAX_EPOCHS (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_x1        (load_x1),
      .load_x2        (load_x2),
      .load_t         (load_t),
      .weight_changed (weight_changed),
      .smp            (smp_if.master),
      .epoch_end      (epoch_end),
      .epoch_cnt      (epoch_cnt),
      .busy           (busy),
      .done           (done),
      .converged      (converged)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int ord(input int ep, input int j);
      return (ALT && (ep % 2 == 1)) ? 3 - j : j;
   endfunction

   task automatic check_sample(input string tag, input int k);
      check({tag, " valid"}, 32'(smp_if.valid), 32'd1);
      check({tag, " idx"},   32'(smp_if.sample_idx), 32'(k));
      check({tag, " x1"},    32'(smp_if.x1), 32'(tx1[k]));
      check({tag, " x2"},    32'(smp_if.x2), 32'(tx2[k]));
      check({tag, " t"},     32'(smp_if.t),  32'(tt[k]));
   endtask

   // Expects PRESENT at entry; leaves the DUT one cycle after EPOCH_CHECK.
   task automatic present_epoch(input int ep, input int wc_sample, input bit slow, input bit wc_in_check);
      int k;
      for (int j = 0; j < 4; j++) begin
         k = ord(ep, j);
         if (slow) begin
            smp_if.ready = 1'b0;
            for (int h = 0; h < 2; h++) begin
               check_sample("hold", k);
               tick();
            end
         end
         smp_if.ready   = 1'b1;
         weight_changed = (j == wc_sample);
         check_sample("xfer", k);
         check("xfer epoch_cnt", 32'(epoch_cnt), 32'(ep));
         tick();
         weight_changed = 1'b0;
      end
      weight_changed = wc_in_check;
      check("chk valid",     32'(smp_if.valid), 32'd0);
      check("chk epoch_end", 32'(epoch_end), 32'd1);
      check("chk busy",      32'(busy), 32'd1);
      check("chk x1 gated",  32'(smp_if.x1), 32'd0);
      check("chk epoch_cnt", 32'(epoch_cnt), 32'(ep));
      tick();
      weight_changed = 1'b0;
   endtask

   task automatic check_done(input int ep, input bit conv);
      check("done",           32'(done), 32'd1);
      check("done busy",      32'(busy), 32'd0);
      check("done valid",     32'(smp_if.valid), 32'd0);
      check("done epoch_end", 32'(epoch_end), 32'd0);
      check("done converged", 32'(converged), 32'(conv));
      check("done epoch_cnt", 32'(epoch_cnt), 32'(ep));
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0;
      load_x1 = '0; load_x2 = '0; load_t = '0; weight_changed = 1'b0;
      smp_if.ready = 1'b0;
      tick(); tick();
      check("rst valid",      32'(smp_if.valid), 32'd0);
      check("rst busy",       32'(busy), 32'd0);
      check("rst done",       32'(done), 32'd0);
      check("rst converged",  32'(converged), 32'd0);
      check("rst epoch_end",  32'(epoch_end), 32'd0);
      check("rst epoch_cnt",  32'(epoch_cnt), 32'd0);
      check("rst sample_idx", 32'(smp_if.sample_idx), 32'd0);
      check("rst x1",         32'(smp_if.x1), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) begin
         load_en = 1'b1; load_addr = 2'(i);
         load_x1 = tx1[i]; load_x2 = tx2[i]; load_t = tt[i];
         tick();
      end
      load_en = 1'b0;

      // single epoch, no updates
      do_start();
      smp_if.ready = 1'b1;
      present_epoch(0, -1, 1'b0, 1'b0);
      check_done(1, 1'b1);

      // updates in epochs 1 and 2 only
      do_start();
      present_epoch(0, 1, 1'b0, 1'b0);
      present_epoch(1, 2, 1'b0, 1'b0);
      present_epoch(2, -1, 1'b0, 1'b0);
      check_done(3, 1'b1);

      // never converges: stops at MAX_EPOCHS
      do_start();
      for (int e = 0; e < 16; e++) present_epoch(e, 0, 1'b0, 1'b0);
      check_done(16, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no 17th valid", 32'(smp_if.valid), 32'd0);
         check("held epoch_cnt", 32'(epoch_cnt), 32'd16);
      end

      // stalled handshake
      do_start();
      present_epoch(0, -1, 1'b1, 1'b0);
      check_done(1, 1'b1);

      // update only in EPOCH_CHECK counts for the finished epoch
      do_start();
      present_epoch(0, -1, 1'b0, 1'b1);
      present_epoch(1, -1, 1'b0, 1'b0);
      check_done(2, 1'b1);

      // reset mid-epoch, with writes attempted while busy
      do_start();
      present_epoch(0, 3, 1'b0, 1'b0);
      load_en = 1'b1; load_addr = 2'(ord(1, 0));
      load_x1 = 8'h77; load_x2 = 8'h66; load_t = 8'h55;
      tick(); tick();
      check("mid idx", 32'(smp_if.sample_idx), 32'(ord(1, 2)));
      check("mid epoch_cnt", 32'(epoch_cnt), 32'd1);
      load_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async valid",     32'(smp_if.valid), 32'd0);
      check("async epoch_cnt", 32'(epoch_cnt), 32'd0);
      check("async busy",      32'(busy), 32'd0);
      check("async x1",        32'(smp_if.x1), 32'd0);
      check("async idx",       32'(smp_if.sample_idx), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      do_start();
      present_epoch(0, -1, 1'b0, 1'b0);
      check_done(1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/neuron_sample_feeder.md
Name: neuron_sample_feeder

Overview:
- Producer side of the neuron training-data interface.
- Holds a small table of training samples (x1, x2, target t) and presents them one at a time to the neuron controller over a valid/ready handshake.
- Repeats passes (epochs) until an epoch completes with no weight update (converged) or MAX_EPOCHS is reached.
- Sits between the host/testbench load port and the neuron controller's data-register load inputs.

Parameters:
- DATA_W, 8, width of x1, x2 and t (two's complement).
- N_SAMPLES, 4, number of table entries (>=2).
- MAX_EPOCHS, 16, epoch limit (>=1).
- IDX_W, $clog2(N_SAMPLES), index width (derived).
- EP_W, $clog2(MAX_EPOCHS+1), epoch counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin training run.
- load_en  in  1  write one table entry.
- load_addr  in  IDX_W  entry index.
- load_x1, load_x2, load_t  in  DATA_W each  entry fields.
- ready  in  1  controller accepts the current sample.
- weight_changed  in  1  controller updated weights this cycle.
- valid  out  1  sample outputs are meaningful.
- x1, x2, t  out  DATA_W each  current sample.
- sample_idx  out  IDX_W  index of the presented sample.
- epoch_end  out  1  one-cycle pulse at the end of each epoch.
- epoch_cnt  out  EP_W  number of completed epochs.
- busy  out  1  run in progress.
- done  out  1  run finished (held).
- converged  out  1  meaningful only when done; 1 means the last epoch made no weight change.

Behaviour:
- Reset values:
  - valid, epoch_end, busy, done and converged = 0.
  - epoch_cnt = 0; sample_idx = 0.
  - x1, x2 and t read 0 whenever valid = 0 (outputs gated).
  - The sample table is not cleared by rst; its contents are preserved.
- Table writes:
  - Accepted only in IDLE or DONE; ignored while busy.
  - A write takes effect one cycle after load_en.
- States: IDLE, PRESENT, EPOCH_CHECK, DONE.
- IDLE:
  - start=1 moves to PRESENT next cycle.
  - On that transition: idx=0, epoch_cnt=0, changed=0, done=0, converged=0.
- PRESENT:
  - valid=1 and busy=1; x1, x2 and t equal table[idx] combinationally.
  - Outputs stay stable until the transfer.
  - Transfer happens on a cycle with valid & ready.
    - If idx < N_SAMPLES-1: idx increments and the next sample is presented the following cycle, so back-to-back transfers are allowed.
    - If idx == N_SAMPLES-1: go to EPOCH_CHECK.
  - ready=0 simply holds the current sample; there is no timeout.
- changed flag:
  - Sticky bit, set by weight_changed in any cycle while busy.
  - Cleared at the start of each epoch.
- EPOCH_CHECK (exactly one cycle):
  - valid=0 and epoch_end=1.
  - Convergence decision uses eff = changed | weight_changed, so a same-cycle update counts toward the finished epoch.
  - If eff=0: epoch_cnt+1, converged=1, go to DONE.
  - Else if epoch_cnt+1 == MAX_EPOCHS: epoch_cnt+1, converged=0, go to DONE.
  - Else: epoch_cnt+1, changed=0, idx=0, go to PRESENT.
- DONE:
  - done=1 and busy=0; epoch_cnt and converged are held.
  - start=1 restarts exactly as from IDLE.
- start outside IDLE or DONE is ignored.
- rst asserted at any time returns to IDLE immediately, with outputs at their reset values.
- epoch_cnt never exceeds MAX_EPOCHS.
- The per-epoch transfer count is exactly N_SAMPLES.

Optional Feature:
- Macro FEEDER_ALT_ORDER_EN.
- When defined:
  - Odd-numbered epochs (epoch_cnt odd at epoch start) present samples in descending order, from N_SAMPLES-1 down to 0.
  - Even epochs present in ascending order.
  - The last-sample test uses idx==0 on descending epochs.
  - sample_idx reports the true table index.
- When undefined: every epoch is ascending. Ports are identical in both builds.

Decomposition:
- Shared package neuron_pkg holds:
  - the state enum feeder_state_t;
  - DATA_W default and the sample struct {x1, x2, t};
  - MAX_EPOCHS default.
- One sub-module is natural: neuron_sample_table.
  - N_SAMPLES x (3*DATA_W) register file.
  - Synchronous write port, asynchronous read port, no reset.
- The FSM, index logic and epoch logic stay in the top.

Test Plan:
- Load table {(1,2,1),(3,-1,-1),(-2,4,1),(0,0,-1)}; start; ready=1 constantly; weight_changed=0 -> four transfers on four consecutive cycles, idx 0..3 with the exact values; epoch_end pulse; done=1, converged=1, epoch_cnt=1.
- Same table; pulse weight_changed once in each of epochs 1-2, none in epoch 3 -> three epoch_end pulses; done with converged=1, epoch_cnt=3.
- weight_changed=1 every epoch with MAX_EPOCHS=16 -> done after 16 epochs; converged=0, epoch_cnt=16; no 17th transfer.
- ready toggled 1,0,0,1,... -> x1, x2 and t stay stable while ready=0; no sample skipped or repeated; transfer count per epoch is 4.
- weight_changed asserted only in the EPOCH_CHECK cycle of epoch 1 -> a second epoch runs, i.e. the update is counted for epoch 1.
- rst asserted mid-epoch at idx=2 -> valid=0 and epoch_cnt=0 immediately; table intact; new start presents idx 0 with the original values; load_en while busy leaves the table unchanged.
